// File: rtl/matrix_loader_pkg.sv
// Shared types for the matrix loader: FSM states, pair layout and a wrap counter helper.
package matrix_loader_pkg;

  typedef enum logic [1:0] {L_IDLE, L_VEC, L_MAT, L_START} LOAD_STATE_e;

  localparam int ELEM_W = 8;

  typedef struct packed {
    logic [ELEM_W-1:0] m;
    logic [ELEM_W-1:0] v;
  } pair_t;

  // Increment a 3-bit counter, returning to zero after 'last'.
  function automatic logic [2:0] wrap_inc(input logic [2:0] val, input logic [2:0] last);
    return (val == last) ? 3'd0 : val + 3'd1;
  endfunction

endpackage

// File: rtl/matrix_loader_vec_regs.sv
// loader_vec_regs: NMAX x DW vector store, one synchronous write port,
// one asynchronous read port, asynchronous active-low reset.
module loader_vec_regs
  import matrix_loader_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NMAX = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [2:0]    waddr,
  input  logic [DW-1:0] wdata,
  input  logic [2:0]    raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [NMAX];

  // Register file write; reset clears every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NMAX; i++) mem[i] <= '0;
    end else if (we) begin
      for (int unsigned i = 0; i < NMAX; i++)
        if (waddr == 3'(i)) mem[i] <= wdata;
    end
  end

  // Asynchronous read; out-of-range addresses return zero.
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NMAX; i++)
      if (raddr == 3'(i)) rdata = mem[i];
  end

endmodule

// File: rtl/matrix_loader.sv
// matrix_loader: takes N vector elements then N*N row-major matrix elements
// and pushes {m[r][c], v[c]} into FIFO (r mod NPROC), then pulses start.
// Optional feature: define LOADER_ABORT_EN to add the abort input.
module matrix_loader
  import matrix_loader_pkg::*;
#(
  parameter int DW    = 8,
  parameter int NPROC = 4,
  parameter int NMAX  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        cfg_n,
  input  logic              cfg_valid,
  input  logic [DW-1:0]     in_data,
  input  logic              in_valid,
`ifdef LOADER_ABORT_EN
  input  logic              abort,
`endif
  output logic              in_ready,
  input  logic [NPROC-1:0]  full,
  output logic [NPROC-1:0]  push,
  output logic [2*DW-1:0]   push_data,
  output logic [2:0]        n_out,
  output logic              start,
  output logic              busy,
  output logic              cfg_err
);

  LOAD_STATE_e state, state_nxt;
  logic [2:0]    col, col_nxt;
  logic [2:0]    row, row_nxt;
  logic [2:0]    proc_idx, proc_nxt;
  logic [2:0]    n_reg, n_nxt;
  logic [2:0]    n_last;
  logic          cfg_err_nxt;
  logic          cfg_legal;
  logic          full_tgt;
  logic          vec_we;
  logic [DW-1:0] vec_rdata;
  logic          abort_i;

`ifdef LOADER_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign n_last    = n_reg - 3'd1;
  assign cfg_legal = (cfg_n != 3'd0) && (cfg_n <= 3'(NMAX));
  assign n_out     = n_reg;
  assign busy      = (state != L_IDLE);
  assign push_data = {in_data, vec_rdata};

  loader_vec_regs #(
    .DW   (DW),
    .NMAX (NMAX)
  ) u_vec (
    .clk   (clk),
    .rst   (rst),
    .we    (vec_we),
    .waddr (col),
    .wdata (in_data),
    .raddr (col),
    .rdata (vec_rdata)
  );

  // State, counter, latched order and error-pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= L_IDLE;
      col      <= '0;
      row      <= '0;
      proc_idx <= '0;
      n_reg    <= '0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      col      <= col_nxt;
      row      <= row_nxt;
      proc_idx <= proc_nxt;
      n_reg    <= n_nxt;
      cfg_err  <= cfg_err_nxt;
    end
  end

  // Next-state, counter updates, handshake and push decode.
  always_comb begin
    state_nxt   = state;
    col_nxt     = col;
    row_nxt     = row;
    proc_nxt    = proc_idx;
    n_nxt       = n_reg;
    cfg_err_nxt = 1'b0;
    in_ready    = 1'b0;
    push        = '0;
    start       = 1'b0;
    vec_we      = 1'b0;
    full_tgt    = 1'b0;

    for (int unsigned i = 0; i < NPROC; i++)
      if (proc_idx == 3'(i)) full_tgt = full[i];

    case (state)
      L_IDLE: begin
        if (cfg_valid) begin
          if (cfg_legal) begin
            n_nxt     = cfg_n;
            col_nxt   = '0;
            row_nxt   = '0;
            proc_nxt  = '0;
            state_nxt = L_VEC;
          end else begin
            cfg_err_nxt = 1'b1;
          end
        end
      end
      L_VEC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          vec_we = 1'b1;
          if (col == n_last) begin
            col_nxt   = '0;
            state_nxt = L_MAT;
          end else begin
            col_nxt = col + 3'd1;
          end
        end
      end
      L_MAT: begin
        in_ready = ~full_tgt;
        if (in_valid && !full_tgt) begin
          for (int unsigned i = 0; i < NPROC; i++)
            if (proc_idx == 3'(i)) push[i] = 1'b1;
          if (col == n_last) begin
            col_nxt  = '0;
            row_nxt  = row + 3'd1;
            proc_nxt = wrap_inc(proc_idx, 3'(NPROC - 1));
            if (row == n_last) state_nxt = L_START;
          end else begin
            col_nxt = col + 3'd1;
          end
        end
      end
      L_START: begin
        start     = 1'b1;
        state_nxt = L_IDLE;
      end
      default: state_nxt = L_IDLE;
    endcase

    // Abort overrides everything decoded above, including a same-cycle transfer.
    if (abort_i) begin
      state_nxt   = L_IDLE;
      col_nxt     = '0;
      row_nxt     = '0;
      proc_nxt    = '0;
      cfg_err_nxt = 1'b0;
      in_ready    = 1'b0;
      push        = '0;
      start       = 1'b0;
      vec_we      = 1'b0;
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader; expected pushes come from a queue
// built directly from the row-major job description.
module tb_matrix_loader;
  import matrix_loader_pkg::*;

  localparam int DW    = 8;
  localparam int NPROC = 4;
  localparam int NMAX  = 7;

  typedef struct packed {
    logic [2:0] fifo;
    pair_t      data;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [2:0]       cfg_n;
  logic             cfg_valid;
  logic [DW-1:0]    in_data;
  logic             in_valid;
  logic             in_ready;
  logic [NPROC-1:0] full;
  logic [NPROC-1:0] push;
  logic [2*DW-1:0]  push_data;
  logic [2:0]       n_out;
  logic             start;
  logic             busy;
  logic             cfg_err;
`ifdef LOADER_ABORT_EN
  logic             abort;
`endif

  int   total;
  int   bad;
  int   starts;
  int   pc [NPROC];
  exp_t expq [$];
  exp_t mon_e;
  int   mon_k;
  logic [7:0] vv [NMAX];
  logic [7:0] mm [NMAX][NMAX];

  matrix_loader #(
    .DW    (DW),
    .NPROC (NPROC),
    .NMAX  (NMAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_n     (cfg_n),
    .cfg_valid (cfg_valid),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef LOADER_ABORT_EN
    .abort     (abort),
`endif
    .in_ready  (in_ready),
    .full      (full),
    .push      (push),
    .push_data (push_data),
    .n_out     (n_out),
    .start     (start),
    .busy      (busy),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Push monitor: every push must match the next expected pair in order.
  always @(negedge clk) begin
    #2;
    if (rst === 1'b1 && push !== '0) begin
      chk("push_onehot", 32'($countones(push)), 32'd1);
      chk("push_vs_full", 32'(push & full), 32'd0);
      mon_k = 0;
      for (int i = 0; i < NPROC; i++) if (push[i]) mon_k = i;
      pc[mon_k]++;
      chk("push_expected", 32'(expq.size() > 0), 32'd1);
      if (expq.size() > 0) begin
        mon_e = expq.pop_front();
        chk("push_fifo", 32'(mon_k), 32'(mon_e.fifo));
        chk("push_data", 32'(push_data), 32'(mon_e.data));
      end
    end
    if (start === 1'b1) starts++;
  end

  // Offer one element and hold it until accepted (bounded).
  task automatic send(input logic [7:0] d);
    int   n;
    logic acc;
    in_data  = d;
    in_valid = 1'b1;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 64) begin
      #1;
      acc = in_ready;
      @(negedge clk);
      n++;
    end
    chk("send_accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_push"},     32'(push),     32'd0);
    chk({tag, "_start"},    32'(start),    32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_cfg_err"},  32'(cfg_err),  32'd0);
    chk({tag, "_n_out"},    32'(n_out),    32'd0);
  endtask

  // mode 0 normal, 1 full stall, 2 abort in row 1, 3 reset after 5 transfers.
  task automatic run_job(input int n, input int mode);
    exp_t e;
    int   s0;
    int   cnt;
    logic [2:0] decoy;
    expq.delete();
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        e.fifo   = 3'(r % NPROC);
        e.data.m = mm[r][c];
        e.data.v = vv[c];
        expq.push_back(e);
      end
    for (int k = 0; k < NPROC; k++) pc[k] = 0;
    s0    = starts;
    decoy = (n == 2) ? 3'd3 : 3'd2;

    cfg_n     = 3'(n);
    cfg_valid = 1'b1;
    @(negedge clk);
    chk("job_busy", 32'(busy), 32'd1);
    chk("job_n_out", 32'(n_out), 32'(n));
    chk("vec_ready", 32'(in_ready), 32'd1);
    cfg_n = decoy;

    for (int c = 0; c < n; c++) send(vv[c]);

    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        if (mode == 3 && n + r * n + c == 5) begin
          cfg_valid = 1'b0;
          in_data   = mm[r][c];
          in_valid  = 1'b1;
          rst       = 1'b0;
          #1;
          check_all_zero("midjob_rst");
          @(negedge clk);
          check_all_zero("midjob_rst_held");
          rst      = 1'b1;
          in_valid = 1'b0;
          expq.delete();
          return;
        end
`ifdef LOADER_ABORT_EN
        if (mode == 2 && r == 1 && c == 1) begin
          cfg_valid = 1'b0;
          in_data   = mm[r][c];
          in_valid  = 1'b1;
          abort     = 1'b1;
          #1;
          chk("abort_ready", 32'(in_ready), 32'd0);
          chk("abort_push", 32'(push), 32'd0);
          @(negedge clk);
          chk("abort_busy", 32'(busy), 32'd0);
          abort    = 1'b0;
          in_valid = 1'b0;
          @(negedge clk);
          chk("abort_no_start", 32'(starts - s0), 32'd0);
          expq.delete();
          return;
        end
`endif
        if (mode == 1 && r == 0 && c == 0) begin
          full     = 4'b1110;
          in_data  = mm[r][c];
          in_valid = 1'b1;
          #1;
          chk("other_full_ready", 32'(in_ready), 32'd1);
        end
        if (mode == 1 && r == 1 && c == 0) full = '0;
        if (mode == 1 && r == 1 && c == 1) begin
          full     = 4'b0010;
          in_data  = mm[r][c];
          in_valid = 1'b1;
          for (int k = 0; k < 4; k++) begin
            #1;
            chk("stall_ready", 32'(in_ready), 32'd0);
            chk("stall_push", 32'(push), 32'd0);
            @(negedge clk);
          end
          full = '0;
        end
        send(mm[r][c]);
      end

    in_data  = 8'hEE;
    in_valid = 1'b1;
    #1;
    chk("start_pulse", 32'(start), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_ready", 32'(in_ready), 32'd0);
    chk("start_push", 32'(push), 32'd0);
    @(negedge clk);
    chk("after_start", 32'(start), 32'd0);
    chk("after_busy", 32'(busy), 32'd0);
    chk("after_cfg_err", 32'(cfg_err), 32'd0);
    chk("after_n_out", 32'(n_out), 32'(n));
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    chk("start_count", 32'(starts - s0), 32'd1);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    for (int k = 0; k < NPROC; k++) begin
      cnt = 0;
      for (int r = 0; r < n; r++) if (r % NPROC == k) cnt += n;
      chk("fifo_push_count", 32'(pc[k]), 32'(cnt));
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    starts    = 0;
    rst       = 1'b0;
    cfg_n     = '0;
    cfg_valid = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    full      = '0;
`ifdef LOADER_ABORT_EN
    abort     = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(in_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;

    // N=2 directed stream 1,2 | 3,4,5,6.
    vv[0] = 8'd1; vv[1] = 8'd2;
    mm[0][0] = 8'd3; mm[0][1] = 8'd4; mm[1][0] = 8'd5; mm[1][1] = 8'd6;
    run_job(2, 0);

    // N=5 random: rows map to FIFOs 0,1,2,3,0.
    for (int i = 0; i < NMAX; i++) begin
      vv[i] = 8'($urandom);
      for (int j = 0; j < NMAX; j++) mm[i][j] = 8'($urandom);
    end
    run_job(5, 0);

    // N=3 with target FIFO full mid-row 1, other FIFOs full in row 0.
    for (int i = 0; i < NMAX; i++) begin
      vv[i] = 8'($urandom);
      for (int j = 0; j < NMAX; j++) mm[i][j] = 8'($urandom);
    end
    run_job(3, 1);

    // Illegal order is rejected with a single error pulse.
    cfg_n     = 3'd0;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("cfg0_err", 32'(cfg_err), 32'd1);
    chk("cfg0_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("cfg0_err_pulse", 32'(cfg_err), 32'd0);
    chk("cfg0_still_idle", 32'(busy), 32'd0);

    // Largest order accepted.
    for (int i = 0; i < NMAX; i++) begin
      vv[i] = 8'($urandom);
      for (int j = 0; j < NMAX; j++) mm[i][j] = 8'($urandom);
    end
    run_job(7, 0);

    // Reset mid-job, then a fresh N=1 job 1 | 9.
    run_job(3, 3);
    chk("post_rst_busy", 32'(busy), 32'd0);
    vv[0] = 8'd1;
    mm[0][0] = 8'd9;
    run_job(1, 0);

`ifdef LOADER_ABORT_EN
    for (int i = 0; i < NMAX; i++) begin
      vv[i] = 8'($urandom);
      for (int j = 0; j < NMAX; j++) mm[i][j] = 8'($urandom);
    end
    run_job(3, 2);
    run_job(2, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
